// File: rtl/tpc_job_dispatcher.sv
// tpc_job_dispatcher: queues TPC job descriptors and hands each one, in order,
// to the lowest-index idle TPC; tracks ownership, completions and errors.
module tpc_job_dispatcher #(
    parameter int NUM_TPCS = 4,
    parameter int PC_W     = 20,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       clear_err,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [PC_W-1:0]            job_pc,
    input  logic [NUM_TPCS-1:0]        job_mask,
    output logic [NUM_TPCS-1:0]        tpc_start,
    output logic [NUM_TPCS*PC_W-1:0]   tpc_start_pc,
    input  logic [NUM_TPCS-1:0]        tpc_busy,
    input  logic [NUM_TPCS-1:0]        tpc_done,
    input  logic [NUM_TPCS-1:0]        tpc_error,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic [NUM_TPCS-1:0]        tpc_owned,
    output logic [CNT_W-1:0]           jobs_completed,
    output logic [NUM_TPCS-1:0]        err_status,
    output logic                       mask_err,
    output logic [1:0]                 state,
    output logic                       irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    logic [PC_W-1:0]          pc_mem_q   [DEPTH];
    logic [NUM_TPCS-1:0]      mask_mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    state_e                   state_q, state_d;
    logic [NUM_TPCS-1:0]      start_q, start_d;
    logic [NUM_TPCS-1:0]      owned_q, owned_d;
    logic [NUM_TPCS-1:0]      err_q, err_d;
    logic [NUM_TPCS*PC_W-1:0] spc_q, spc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     mask_err_q, mask_err_d;
    logic                     irq_q, irq_d;

    logic                     full, push, pop, can_issue;
    logic [PC_W-1:0]          head_pc;
    logic [NUM_TPCS-1:0]      head_mask, elig, disp_oh;
    logic [NUM_TPCS-1:0]      done_hit, err_hit;
    logic [CNT_W-1:0]         done_num;

    assign full      = (count_q == CW'(DEPTH));
    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign head_mask = mask_mem_q[rd_ptr_q];
    assign elig      = head_mask & ~owned_q & ~tpc_busy & ~err_q;
    assign can_issue = !flush && (state_q == ST_RUN) && enable
                       && (count_q != '0);
    assign push      = job_valid && !full && !flush;
    // An error on an owned TPC takes precedence over a coincident done.
    assign done_hit  = tpc_done & owned_q & ~tpc_error;
    assign err_hit   = tpc_error & owned_q;

    always_comb begin
        pop        = 1'b0;
        disp_oh    = '0;
        mask_err_d = mask_err_q;
        spc_d      = spc_q;
        if (can_issue) begin
            if (head_mask == '0) begin
                pop        = 1'b1;
                mask_err_d = 1'b1;
            end else if (elig != '0) begin
                pop     = 1'b1;
                disp_oh = elig & (~elig + NUM_TPCS'(1));
            end
        end
        for (int i = 0; i < NUM_TPCS; i++) begin
            if (disp_oh[i]) spc_d[i*PC_W +: PC_W] = head_pc;
        end
    end

    always_comb begin
        done_num = '0;
        for (int i = 0; i < NUM_TPCS; i++) begin
            done_num = done_num + CNT_W'(done_hit[i]);
        end
        owned_d = (owned_q & ~done_hit & ~err_hit) | disp_oh;
        cnt_d   = cnt_q + done_num;
        start_d = disp_oh;
        err_d   = (flush || clear_err) ? '0 : err_q;
        err_d   = err_d | tpc_error;
        irq_d   = (owned_q != '0) && (owned_d == '0) && (done_hit != '0)
                  && (count_q == '0) && (state_q != ST_HALT);
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_DRAIN;
        end else if (err_hit != '0) begin
            state_d = ST_HALT;
        end else if (state_q == ST_HALT && clear_err) begin
            state_d = ST_RUN;
        end else if (state_q == ST_DRAIN && owned_q == '0) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= job_pc;
            mask_mem_q[wr_ptr_q] <= job_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_RUN;
            start_q    <= '0;
            owned_q    <= '0;
            err_q      <= '0;
            spc_q      <= '0;
            cnt_q      <= '0;
            mask_err_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            start_q    <= start_d;
            owned_q    <= owned_d;
            err_q      <= err_d;
            spc_q      <= spc_d;
            cnt_q      <= cnt_d;
            mask_err_q <= mask_err_d;
            irq_q      <= irq_d;
        end
    end

    assign job_ready      = !full;
    assign queue_count    = count_q;
    assign tpc_start      = start_q;
    assign tpc_start_pc   = spc_q;
    assign tpc_owned      = owned_q;
    assign jobs_completed = cnt_q;
    assign err_status     = err_q;
    assign mask_err       = mask_err_q;
    assign state          = state_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_tpc_job_dispatcher.sv
// tb_tpc_job_dispatcher: directed and randomized checks of the dispatcher
// against a queue-based reference model.
module tb_tpc_job_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, flush, clear_err, job_valid, job_ready;
    logic [19:0] job_pc;
    logic [3:0]  job_mask, tpc_start, tpc_busy, tpc_done, tpc_error;
    logic [79:0] tpc_start_pc;
    logic [3:0]  queue_count;
    logic [3:0]  tpc_owned, err_status;
    logic [15:0] jobs_completed;
    logic        mask_err, irq;
    logic [1:0]  state;

    int n_chk = 0;
    int n_fail = 0;

    tpc_job_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .clear_err(clear_err), .job_valid(job_valid),
        .job_ready(job_ready), .job_pc(job_pc), .job_mask(job_mask),
        .tpc_start(tpc_start), .tpc_start_pc(tpc_start_pc),
        .tpc_busy(tpc_busy), .tpc_done(tpc_done), .tpc_error(tpc_error),
        .queue_count(queue_count), .tpc_owned(tpc_owned),
        .jobs_completed(jobs_completed), .err_status(err_status),
        .mask_err(mask_err), .state(state), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] pc;
        logic [3:0]  mask;
    } job_t;

    job_t        m_q[$];
    logic [3:0]  m_own, m_err, m_start;
    logic [19:0] m_spc[4];
    logic [15:0] m_cnt;
    bit          m_merr, m_irq;
    int          m_st;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_own = '0; m_err = '0; m_start = '0; m_cnt = '0;
        m_merr = 0; m_irq = 0; m_st = 0;
        for (int i = 0; i < 4; i++) m_spc[i] = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int pick = -1;
        int n0 = m_q.size();
        logic [3:0] own0 = m_own;
        bit halt_req = 0;
        bit any_done = 0;
        job_t j;
        m_start = '0;
        m_irq = 0;
        if (!flush && m_st == 0 && enable && n0 > 0) begin
            if (m_q[0].mask == 4'd0) begin
                void'(m_q.pop_front());
                m_merr = 1;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (pick < 0 && m_q[0].mask[i] && !own0[i]
                        && !tpc_busy[i] && !m_err[i]) pick = i;
                if (pick >= 0) begin
                    m_start[pick] = 1'b1;
                    m_spc[pick] = m_q[0].pc;
                    void'(m_q.pop_front());
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (own0[i] && tpc_error[i]) begin
                m_own[i] = 1'b0;
                halt_req = 1;
            end else if (own0[i] && tpc_done[i]) begin
                m_own[i] = 1'b0;
                m_cnt = m_cnt + 16'd1;
                any_done = 1;
            end
        end
        if (pick >= 0) m_own[pick] = 1'b1;
        if (flush || clear_err) m_err = '0;
        m_err = m_err | tpc_error;
        if (flush) m_q.delete();
        else if (job_valid && n0 < 8) begin
            j.pc = job_pc;
            j.mask = job_mask;
            m_q.push_back(j);
        end
        if (any_done && own0 != 0 && m_own == 0 && n0 == 0 && m_st != 2)
            m_irq = 1;
        if (flush) m_st = 1;
        else if (halt_req) m_st = 2;
        else if (m_st == 2 && clear_err) m_st = 0;
        else if (m_st == 1 && own0 == 0) m_st = 0;
    endtask

    task automatic compare_all();
        logic [79:0] pcv;
        for (int i = 0; i < 4; i++) pcv[i*20 +: 20] = m_spc[i];
        chk("start", tpc_start, m_start);
        chk("start_pc", tpc_start_pc, pcv);
        chk("owned", tpc_owned, m_own);
        chk("qcount", queue_count, m_q.size());
        chk("ready", job_ready, m_q.size() < 8);
        chk("completed", jobs_completed, m_cnt);
        chk("err_status", err_status, m_err);
        chk("mask_err", mask_err, m_merr);
        chk("state", state, m_st);
        chk("irq", irq, m_irq);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        enable = 1; flush = 0; clear_err = 0; job_valid = 0;
        job_pc = '0; job_mask = '0;
        tpc_busy = '0; tpc_done = '0; tpc_error = '0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_start", tpc_start, 4'd0);
        chk("rst_state", state, 2'd0);
        chk("rst_qcount", queue_count, 4'd0);
        chk("rst_ready", job_ready, 1'b1);
        rst_n = 1;
        @(negedge clk);
        compare_all();

        // single job on TPC0, then completion with irq
        job_valid = 1; job_pc = 20'h00100; job_mask = 4'b1111;
        step();
        chk("sj_qcount", queue_count, 4'd1);
        job_valid = 0;
        step();
        chk("sj_start", tpc_start, 4'b0001);
        chk("sj_pc", tpc_start_pc[19:0], 20'h00100);
        step();
        chk("sj_pulse", tpc_start, 4'b0000);
        tpc_done = 4'b0001;
        step();
        tpc_done = '0;
        chk("sj_cnt", jobs_completed, 16'd1);
        chk("sj_irq", irq, 1'b1);
        step();
        chk("sj_irq_end", irq, 1'b0);

        // zero-mask job is dropped
        job_valid = 1; job_mask = 4'b0000; job_pc = 20'h00abc;
        step();
        job_valid = 0;
        step();
        chk("zm_err", mask_err, 1'b1);
        chk("zm_start", tpc_start, 4'b0000);

        // error on owned TPC3 halts, clear_err resumes
        job_valid = 1; job_mask = 4'b1000; job_pc = 20'h00333;
        step();
        job_valid = 0;
        step();
        chk("er_owned", tpc_owned, 4'b1000);
        tpc_error = 4'b1000;
        step();
        tpc_error = '0;
        chk("er_status", err_status, 4'b1000);
        chk("er_halt", state, 2'd2);
        clear_err = 1;
        step();
        clear_err = 0;
        chk("er_run", state, 2'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 60) == 0);
            clear_err = ($urandom_range(0, 15) == 0);
            job_valid = $urandom_range(0, 1);
            job_pc    = 20'($urandom);
            job_mask  = 4'($urandom_range(0, 15));
            tpc_busy  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tpc_done  = 4'($urandom) & 4'($urandom);
            tpc_error = ($urandom_range(0, 40) == 0)
                        ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            step();
        end

        // asynchronous reset in the middle of traffic
        idle();
        job_valid = 1; job_mask = 4'b1111; job_pc = 20'h00777;
        step();
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("ar_start", tpc_start, 4'd0);
        chk("ar_owned", tpc_owned, 4'd0);
        chk("ar_pc", tpc_start_pc, 80'd0);
        chk("ar_qcount", queue_count, 4'd0);
        chk("ar_cnt", jobs_completed, 16'd0);
        chk("ar_state", state, 2'd0);
        idle();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        compare_all();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
